dvp_pattern_source: RTL
=======================

// Module: dvp_pattern_source
// PURPOSE
// Synthetic OV2640-style DVP transmitter: drives VSYNC/HREF/PIXDATA (Y8) with built-in test patterns.
// Replaces the camera on the pixel-input side of the frame buffer for bring-up and simulation.
// Runs in the PIXCLK domain. The port carrying its clock is the PIXCLK seen by the frame buffer.
// PARAMETERS
// H_ACTIVE  640   active pixels per line (HREF high)
// H_BLANK   144   blank cycles per line after the active pixels (HREF low); H_TOTAL = H_ACTIVE+H_BLANK
// V_ACTIVE  480   active lines per frame
// VS_LINES  3     line periods with VSYNC asserted
// V_BPORCH  17    line periods between the VSYNC deassert and the first active line
// V_FPORCH  10    line periods after the last active line
// VS_POL    1'b0  VSYNC polarity: 0 = active-low (matches vs_n input), 1 = active-high
// PORTS
// iclk         in   1  pixel clock; all logic on rising edge
// irst_n       in   1  asynchronous, active-low reset
// ienable      in   1  level; frame generation allowed; sampled only at frame boundaries
// ipattern     in   2  pattern select; latched at frame start
// ovsync       out  1  frame sync, polarity per VS_POL
// ohref        out  1  line valid; high only during active pixels
// opixdata     out  8  Y8 pixel; 8'h00 whenever ohref=0
// oframe_done  out  1  one-cycle pulse on the last cycle of the front porch
// oframe_cnt   out  8  completed-frame counter
// BEHAVIOUR
// - All outputs registered. On reset: ovsync=~VS_POL (inactive), ohref=0, opixdata=0, oframe_done=0, oframe_cnt=0, FSM=IDLE.
// - Async reset mid-frame aborts the frame immediately; no partial-frame completion; counters cleared.
// - FSM: IDLE -> VSYNC -> VBP -> ACTIVE -> VFP -> (IDLE | VSYNC).
//   IDLE: outputs inactive; if ienable=1 at cycle t, ovsync becomes active at t+1, FSM=VSYNC.
//   VSYNC: ovsync active for exactly VS_LINES*H_TOTAL cycles, then inactive; -> VBP.
//   VBP: V_BPORCH*H_TOTAL cycles, all outputs inactive; -> ACTIVE.
//   ACTIVE: V_ACTIVE lines; each line = H_ACTIVE cycles ohref=1 with data, then H_BLANK cycles ohref=0.
//   VFP: V_FPORCH*H_TOTAL cycles inactive; last cycle raises oframe_done and increments oframe_cnt (8-bit, 255 wraps to 0).
//   End of VFP: if ienable=1, next cycle is the first VSYNC cycle (back-to-back frames, no IDLE gap); else -> IDLE.
// - Frame length when back-to-back: H_TOTAL*(VS_LINES+V_BPORCH+V_ACTIVE+V_FPORCH) cycles exactly.
// - ienable deassert mid-frame: the current frame completes in full; no new frame starts.
// - ipattern change mid-frame is ignored until the next VSYNC entry.
// - Counters: x in 0..H_ACTIVE-1 and y in 0..V_ACTIVE-1 for active pixels. Widths use $clog2 of the maximum.
// - Patterns (pixel = f(x,y)), updated on the same edge that drives ohref:
//   0: x[7:0] (horizontal ramp, wraps every 256)
//   1: y[7:0] (vertical ramp)
//   2: (x[3]^y[3]) ? 8'hFF : 8'h00 (8x8 checkerboard)
//   3: x[7:0] + latched frame count (mod 256, scrolling ramp)
// - The first ohref=1 cycle of each line carries x=0. ohref and opixdata change on the same edge; no skew.
// TESTING
// Small params: H_ACTIVE=8, H_BLANK=4, V_ACTIVE=4, VS_LINES=1, V_BPORCH=1, V_FPORCH=1, VS_POL=0.
// 1) Reset, ienable=1, ipattern=0 -> ovsync low 12 cycles; then 12 inactive; then 4 lines of ohref 8 high / 4 low
//    with data 0..7 each line; oframe_done pulses at cycle 84 of the frame; oframe_cnt=1.
// 2) Hold ienable=1 for 3 frames -> VSYNC falls every 84 cycles exactly; oframe_cnt=3; no IDLE gap.
// 3) ipattern=2, H_ACTIVE=16, V_ACTIVE=16 -> line 0 data 00x8 then FFx8; line 8 data FFx8 then 00x8.
// 4) Drop ienable during line 2 -> frame finishes, oframe_done pulses once, outputs stay inactive afterwards.
// 5) ipattern=3 across frames -> frame n line data = (x+n) mod 256; ipattern switched mid-frame takes effect only next frame.
// 6) Assert irst_n=0 mid-ACTIVE -> same cycle ohref=0, opixdata=0, ovsync=1; after release with ienable=1, a clean frame restarts from VSYNC.

Source files
------------

// File: rtl/dvp_pattern_source_if.sv
// DVP output bundle of the synthetic pattern source: sync, line-valid, Y8 data and frame status.
// The source drives it through the master modport; a frame-buffer front end samples it as slave.
interface dvp_pattern_source_if;
    logic       ovsync;
    logic       ohref;
    logic [7:0] opixdata;
    logic       oframe_done;
    logic [7:0] oframe_cnt;

    modport master (
        output ovsync,
        output ohref,
        output opixdata,
        output oframe_done,
        output oframe_cnt
    );

    modport slave (
        input ovsync,
        input ohref,
        input opixdata,
        input oframe_done,
        input oframe_cnt
    );
endinterface

// File: rtl/dvp_pattern_source.sv
// Synthetic OV2640-style DVP transmitter generating VSYNC/HREF/Y8 test patterns in the PIXCLK domain.
// Every output is a flop; next-state and next-output logic are computed from the same _d values.
module dvp_pattern_source #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_BLANK  = 144,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned VS_LINES = 3,
    parameter int unsigned V_BPORCH = 17,
    parameter int unsigned V_FPORCH = 10,
    parameter logic        VS_POL   = 1'b0
) (
    input  logic                        iclk,
    input  logic                        irst_n,
    input  logic                        ienable,
    input  logic [1:0]                  ipattern,
    dvp_pattern_source_if.master        dvp
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int unsigned MaxA    = (VS_LINES > V_BPORCH) ? VS_LINES : V_BPORCH;
    localparam int unsigned MaxB    = (V_ACTIVE > V_FPORCH) ? V_ACTIVE : V_FPORCH;
    localparam int unsigned MaxLine = (MaxA > MaxB) ? MaxA : MaxB;
    localparam int unsigned HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int unsigned LW      = (MaxLine > 1) ? $clog2(MaxLine) : 1;

    localparam logic [HW-1:0] HLast    = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] HActEnd  = HW'(H_ACTIVE);
    localparam logic [LW-1:0] VsLast   = LW'(VS_LINES - 1);
    localparam logic [LW-1:0] VbpLast  = LW'(V_BPORCH - 1);
    localparam logic [LW-1:0] VactLast = LW'(V_ACTIVE - 1);
    localparam logic [LW-1:0] VfpLast  = LW'(V_FPORCH - 1);

    typedef enum logic [2:0] {StIdle, StVsync, StVbp, StActive, StVfp} state_e;

    state_e        state_q, state_d;
    logic [HW-1:0] h_q, h_d;
    logic [LW-1:0] l_q, l_d;
    logic [1:0]    pat_q, pat_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          vsync_q, vsync_d;
    logic          href_q, href_d;
    logic [7:0]    pix_q, pix_d;
    logic          done_q, done_d;

    logic [LW-1:0] l_last;
    logic [7:0]    x8, y8, pat_pix;

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        l_d     = l_q;
        pat_d   = pat_q;
        l_last  = '0;

        unique case (state_q)
            StVsync:  l_last = VsLast;
            StVbp:    l_last = VbpLast;
            StActive: l_last = VactLast;
            StVfp:    l_last = VfpLast;
            default:  l_last = '0;
        endcase

        if (state_q == StIdle) begin
            if (ienable) begin
                state_d = StVsync;
            end
        end else begin
            h_d = (h_q == HLast) ? '0 : h_q + 1'b1;
            if (h_q == HLast) begin
                if (l_q == l_last) begin
                    l_d = '0;
                    unique case (state_q)
                        StVsync:  state_d = StVbp;
                        StVbp:    state_d = StActive;
                        StActive: state_d = StVfp;
                        // ienable is only looked at here and in IDLE, so a frame always completes
                        StVfp:    state_d = ienable ? StVsync : StIdle;
                        default:  state_d = StIdle;
                    endcase
                end else begin
                    l_d = l_q + 1'b1;
                end
            end
        end

        if ((state_d == StVsync) && (state_q != StVsync)) begin
            pat_d = ipattern;
        end
    end

    // Outputs are derived from the next-cycle position so they register together with the FSM.
    always_comb begin
        x8 = 8'(h_d);
        y8 = 8'(l_d);
        unique case (pat_q)
            2'd0:    pat_pix = x8;
            2'd1:    pat_pix = y8;
            2'd2:    pat_pix = (x8[3] ^ y8[3]) ? 8'hFF : 8'h00;
            default: pat_pix = x8 + cnt_q;
        endcase

        vsync_d = (state_d == StVsync) ? VS_POL : ~VS_POL;
        href_d  = (state_d == StActive) && (h_d < HActEnd);
        pix_d   = href_d ? pat_pix : 8'h00;
        done_d  = (state_d == StVfp) && (h_d == HLast) && (l_d == VfpLast);
        cnt_d   = cnt_q + {7'd0, done_d};
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state_q <= StIdle;
            h_q     <= '0;
            l_q     <= '0;
            pat_q   <= 2'd0;
            cnt_q   <= 8'd0;
            vsync_q <= ~VS_POL;
            href_q  <= 1'b0;
            pix_q   <= 8'h00;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            l_q     <= l_d;
            pat_q   <= pat_d;
            cnt_q   <= cnt_d;
            vsync_q <= vsync_d;
            href_q  <= href_d;
            pix_q   <= pix_d;
            done_q  <= done_d;
        end
    end

    assign dvp.ovsync      = vsync_q;
    assign dvp.ohref       = href_q;
    assign dvp.opixdata    = pix_q;
    assign dvp.oframe_done = done_q;
    assign dvp.oframe_cnt  = cnt_q;

endmodule
